// File: rtl/fx_pkg.sv
// Shared fixed-point constants and FSM state encoding for the QMC normal generator
// datapath stages.
package fx_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int FRAC_DEF  = 16;

  localparam logic [WIDTH_DEF-1:0] SAT_DEF = {1'b0, {(WIDTH_DEF-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fx_isqrt_step.sv
// One digit-by-digit square-root iteration: brings in the next radicand bit pair and
// decides the next root bit from the borrow of the trial subtraction.
module fx_isqrt_step #(
  parameter int ROOT_BITS = 24
) (
  input  logic [ROOT_BITS+1:0] rem,
  input  logic [ROOT_BITS-1:0] root,
  input  logic [1:0]           bit_pair,
  output logic [ROOT_BITS+1:0] rem_next,
  output logic [ROOT_BITS-1:0] root_next
);

  logic [ROOT_BITS+1:0] rem_sh_s;
  logic [ROOT_BITS+2:0] trial_s;

  // Trial subtraction one bit wider than rem so its MSB acts as the borrow flag
  always_comb begin
    rem_sh_s = (rem << 2) | {{ROOT_BITS{1'b0}}, bit_pair};
    trial_s  = {1'b0, rem_sh_s} - {1'b0, root, 2'b01};
    if (!trial_s[ROOT_BITS+2]) begin
      rem_next  = trial_s[ROOT_BITS+1:0];
      root_next = (root << 1) | {{(ROOT_BITS-1){1'b0}}, 1'b1};
    end else begin
      rem_next  = rem_sh_s;
      root_next = root << 1;
    end
  end

endmodule

// File: rtl/fx_bm_radius.sv
// Box-Muller radius stage: r = sqrt(-2*ln(u)) via a bit-serial square root, one
// sample in flight, valid/ready on both sides.
module fx_bm_radius
  import fx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ln_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r_out,
  output logic             clamp_out
);

  localparam int RAD_W     = WIDTH + FRAC;
  localparam int ROOT_BITS = RAD_W / 2;
  localparam int CNT_W     = $clog2(ROOT_BITS);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] LN_MIN  = {2'b11, {(WIDTH-2){1'b0}}};

  state_t               state_r, state_s;
  logic [RAD_W-1:0]     rad_r;
  logic [ROOT_BITS+1:0] rem_r, rem_next_s;
  logic [ROOT_BITS-1:0] root_r, root_next_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [WIDTH-1:0]     t_s;
  logic                 clamp_s;

  fx_isqrt_step #(.ROOT_BITS(ROOT_BITS)) u_step (
    .rem       (rem_r),
    .root      (root_r),
    .bit_pair  (rad_r[RAD_W-1 -: 2]),
    .rem_next  (rem_next_s),
    .root_next (root_next_s)
  );

  // t = -2*ln_in; above LN_MIN the doubled value fits WIDTH bits and its negation is exact
  always_comb begin
    clamp_s = 1'b0;
    t_s     = {WIDTH{1'b0}};
    if ($signed(ln_in) > $signed({WIDTH{1'b0}})) begin
      clamp_s = 1'b1;
    end else if ($signed(ln_in) < $signed(LN_MIN)) begin
      t_s = SAT_MAX;
    end else begin
      t_s = -(ln_in << 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (in_valid)       state_s = CALC; else state_s = IDLE;
      CALC:    if (cnt_r == '0)    state_s = DONE; else state_s = CALC;
      DONE:    if (out_ready)      state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_r == IDLE);
    out_valid = (state_r == DONE);
  end

  // Datapath registers; r_out is captured from the final iteration and then held
  always_ff @(posedge clk) begin
    if (rst) begin
      rad_r     <= {RAD_W{1'b0}};
      rem_r     <= {(ROOT_BITS+2){1'b0}};
      root_r    <= {ROOT_BITS{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      r_out     <= {WIDTH{1'b0}};
      clamp_out <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            rad_r     <= {t_s, {FRAC{1'b0}}};
            rem_r     <= {(ROOT_BITS+2){1'b0}};
            root_r    <= {ROOT_BITS{1'b0}};
            cnt_r     <= CNT_W'(ROOT_BITS - 1);
            clamp_out <= clamp_s;
          end
        end
        CALC: begin
          rad_r  <= rad_r << 2;
          rem_r  <= rem_next_s;
          root_r <= root_next_s;
          if (cnt_r == '0) begin
            r_out <= {{(WIDTH-ROOT_BITS){1'b0}}, root_next_s};
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          rad_r <= rad_r;
        end
        default: begin
          rad_r <= rad_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx_bm_radius.sv
// Directed bench for fx_bm_radius: hand-computed radii, latency, clamp/saturation,
// backpressure and mid-calculation reset.
module tb_fx_bm_radius;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ln_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] r_out;
  logic        clamp_out;

  int checks = 0;
  int passes = 0;

  fx_bm_radius dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ln_in     (ln_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r_out     (r_out),
    .clamp_out (clamp_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs === exp_v) begin
      passes++;
    end else begin
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge after the handshake.
  task automatic run_sample(input string tag, input logic [31:0] ln,
                            input logic [31:0] exp_r, input logic exp_clamp,
                            input int hold);
    int n;
    logic [31:0] junk;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    ln_in    = ln;
    @(negedge clk);
    in_valid = 1'b0;
    ln_in    = 32'h0000_0000;
    chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 32'd24);
    chk({tag, "_r"}, r_out, exp_r);
    chk({tag, "_clamp"}, {31'd0, clamp_out}, {31'd0, exp_clamp});
    for (int i = 0; i < hold; i++) begin
      junk     = 32'hFFFF_0000 | 32'(i);
      in_valid = 1'b1;
      ln_in    = junk;
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_r"}, r_out, exp_r);
      chk({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    ln_in     = 32'h0000_0000;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    ln_in     = 32'h0000_0000;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_r_out", r_out, 32'd0);
    chk("rst_clamp", {31'd0, clamp_out}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_sample("zero",     32'h0000_0000, 32'h0000_0000, 1'b0, 0);
    run_sample("ln_half",  32'hFFFF_4E8E, 32'h0001_2D6A, 1'b0, 0);
    run_sample("ln_2m16",  32'(-726817),  32'h0004_B5AA, 1'b0, 0);
    run_sample("sat_min",  32'h8000_0000, 32'h00B5_04F3, 1'b0, 0);
    run_sample("sat_edge", 32'hBFFF_FFFF, 32'h00B5_04F3, 1'b0, 0);
    run_sample("no_sat",   32'hC000_0000, 32'h00B5_04F3, 1'b0, 0);
    run_sample("ln_m1",    32'hFFFF_FFFF, 32'h0000_016A, 1'b0, 0);
    run_sample("pos",      32'h0001_0000, 32'h0000_0000, 1'b1, 0);
    run_sample("zero2",    32'h0000_0000, 32'h0000_0000, 1'b0, 0);
    run_sample("pos_max",  32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 0);
    run_sample("bp",       32'hFFFF_4E8E, 32'h0001_2D6A, 1'b0, 10);
    run_sample("bp_next",  32'h0000_0000, 32'h0000_0000, 1'b0, 0);

    // Abandon a sample at the 10th calculation cycle; inputs during reset are ignored
    in_valid = 1'b1;
    ln_in    = 32'hFFFF_4E8E;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    ln_in    = 32'h8000_0000;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    ln_in    = 32'h0000_0000;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_no_out", seen, 32'd0);
    chk("mid_rst_idle", {31'd0, in_ready}, 32'd1);
    run_sample("after_rst", 32'hFFFF_4E8E, 32'h0001_2D6A, 1'b0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
